// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and writeback mux helper for the data-memory access stage.
package mem_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // A store always writes back its ALU result, whatever the select field says.
  function automatic logic [31:0] wb_mux(
    input logic [1:0]  sel,
    input logic        is_store,
    input logic        is_load,
    input logic [31:0] alu,
    input logic [31:0] pc4,
    input logic [31:0] rdata
  );
    if (is_store) begin
      return alu;
    end else if (is_load) begin
      return rdata;
    end else if (sel == WB_SEL_PC4) begin
      return pc4;
    end else begin
      return alu;
    end
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts consecutive un-acknowledged WAIT cycles; timeout fires on the TIMEOUT_CYCLES-th one.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic count_en,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_r;

  assign timeout = count_en && (count_r == CW'(TIMEOUT_CYCLES - 1));

  // Count while waiting; clear on leaving WAIT, on ack, or on abort.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count_r <= '0;
    end else if (count_en && !timeout) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= '0;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: issues one data-memory request per load/store, stalls until MemAck, feeds MEM/WB.
// Optional feature macro: MEM_TIMEOUT_EN (abort a request after TIMEOUT_CYCLES WAIT cycles).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        RegWriteEN_In,
  input  logic        MemWriteEN_In,
  input  logic [1:0]  Mem2RegSEL_In,
  input  logic [31:0] ALUResult_In,
  input  logic [31:0] WriteData_In,
  input  logic [31:0] PCPlus4_In,
  input  logic [4:0]  RegWBAddr_In,
  output logic        MemReq,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        Stall,
  output logic        RegWriteEN_Out,
  output logic [4:0]  RegWBAddr_Out,
  output logic [31:0] WBData_Out,
  output logic        MemError
);

  mem_state_e  state_r;
  logic        mem_error_r;
  logic        is_store_s;
  logic        is_load_s;
  logic        access_s;
  logic        timeout_s;
  logic        stall_s;
  logic [31:0] wb_next_s;

  assign is_store_s = MemWriteEN_In;
  assign is_load_s  = !MemWriteEN_In && (Mem2RegSEL_In == WB_SEL_MEM);
  assign access_s   = is_store_s || is_load_s;
  assign wb_next_s  = wb_mux(Mem2RegSEL_In, is_store_s, is_load_s,
                             ALUResult_In, PCPlus4_In, MemRData);

`ifdef MEM_TIMEOUT_EN
  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .count_en((state_r == ST_WAIT) && !MemAck),
    .timeout (timeout_s)
  );
`else
  logic unused_cfg_s;
  assign unused_cfg_s = (TIMEOUT_CYCLES == 0);
  assign timeout_s    = 1'b0;
`endif

  // Stall: raised on an access in IDLE, held in WAIT until ack (or abort).
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      ST_IDLE: stall_s = access_s;
      ST_WAIT: stall_s = !MemAck && !timeout_s;
      default: stall_s = 1'b0;
    endcase
  end

  assign Stall    = stall_s;
  assign MemError = mem_error_r;

  // Access FSM, memory-side request registers and MEM/WB pipeline register.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_r        <= ST_IDLE;
      MemReq         <= 1'b0;
      MemWE          <= 1'b0;
      MemAddr        <= 32'h0;
      MemWData       <= 32'h0;
      RegWriteEN_Out <= 1'b0;
      RegWBAddr_Out  <= 5'd0;
      WBData_Out     <= 32'h0;
      mem_error_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (access_s) begin
            state_r        <= ST_WAIT;
            MemReq         <= 1'b1;
            MemWE          <= MemWriteEN_In;
            MemAddr        <= ALUResult_In;
            MemWData       <= WriteData_In;
            RegWriteEN_Out <= 1'b0;
          end else begin
            RegWriteEN_Out <= RegWriteEN_In;
            RegWBAddr_Out  <= RegWBAddr_In;
            WBData_Out     <= wb_next_s;
          end
        end
        ST_WAIT: begin
          if (MemAck) begin
            state_r        <= ST_IDLE;
            MemReq         <= 1'b0;
            MemWE          <= 1'b0;
            RegWriteEN_Out <= RegWriteEN_In;
            RegWBAddr_Out  <= RegWBAddr_In;
            WBData_Out     <= wb_next_s;
          end else if (timeout_s) begin
            // Abort: the instruction retires as a bubble and the error sticks until reset.
            state_r        <= ST_IDLE;
            MemReq         <= 1'b0;
            MemWE          <= 1'b0;
            RegWriteEN_Out <= 1'b0;
            mem_error_r    <= 1'b1;
          end else begin
            RegWriteEN_Out <= 1'b0;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          MemReq         <= 1'b0;
          MemWE          <= 1'b0;
          RegWriteEN_Out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus queues expected WB and memory requests, a monitor checks them.
module tb_mem_access_unit;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        RegWriteEN_In, MemWriteEN_In;
  logic [1:0]  Mem2RegSEL_In;
  logic [31:0] ALUResult_In, WriteData_In, PCPlus4_In;
  logic [4:0]  RegWBAddr_In;
  logic        MemReq, MemWE;
  logic [31:0] MemAddr, MemWData;
  logic        MemAck;
  logic [31:0] MemRData;
  logic        Stall;
  logic        RegWriteEN_Out;
  logic [4:0]  RegWBAddr_Out;
  logic [31:0] WBData_Out;
  logic        MemError;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic memreq_prev = 1'b0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .RegWriteEN_In (RegWriteEN_In),
    .MemWriteEN_In (MemWriteEN_In),
    .Mem2RegSEL_In (Mem2RegSEL_In),
    .ALUResult_In  (ALUResult_In),
    .WriteData_In  (WriteData_In),
    .PCPlus4_In    (PCPlus4_In),
    .RegWBAddr_In  (RegWBAddr_In),
    .MemReq        (MemReq),
    .MemWE         (MemWE),
    .MemAddr       (MemAddr),
    .MemWData      (MemWData),
    .MemAck        (MemAck),
    .MemRData      (MemRData),
    .Stall         (Stall),
    .RegWriteEN_Out(RegWriteEN_Out),
    .RegWBAddr_Out (RegWBAddr_Out),
    .WBData_Out    (WBData_Out),
    .MemError      (MemError)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every registered writeback and every new memory request is matched against the queues.
  always @(negedge CLOCK) begin
    if (RegWriteEN_Out) begin
      if (wb_q.size() == 0) begin
        check("wb_unexpected", {27'd0, RegWBAddr_Out, WBData_Out}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        check("wb_rd", 64'(RegWBAddr_Out), 64'(e.rd));
        check("wb_data", 64'(WBData_Out), 64'(e.data));
      end
    end
    if (MemReq && !memreq_prev) begin
      if (req_q.size() == 0) begin
        check("req_unexpected", 64'(MemAddr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        req_t r;
        r = req_q.pop_front();
        check("req_addr", 64'(MemAddr), 64'(r.addr));
        check("req_wdata", 64'(MemWData), 64'(r.wdata));
        check("req_we", 64'(MemWE), 64'(r.we));
      end
    end
    memreq_prev = MemReq;
  end

  task automatic set_nop();
    RegWriteEN_In = 1'b0;
    MemWriteEN_In = 1'b0;
    Mem2RegSEL_In = 2'b00;
    ALUResult_In  = 32'h0;
    WriteData_In  = 32'h0;
    PCPlus4_In    = 32'h0;
    RegWBAddr_In  = 5'd0;
  endtask

  task automatic idle(input int n);
    set_nop();
    MemAck = 1'b0;
    repeat (n) begin
      @(posedge CLOCK); #1;
    end
  endtask

  // One instruction held for its IDLE cycle plus exp_req WAIT cycles; ack on the last WAIT cycle if give_ack.
  task automatic do_instr(input string nm, input logic we, input logic rw, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                          input logic [4:0] rd, input int exp_req, input logic [31:0] rdata,
                          input logic give_ack, input logic ack_idle, input logic [31:0] exp_wb,
                          input int exp_stall);
    int stall_cnt;
    int req_cnt;
    wb_t  e;
    req_t r;
    stall_cnt = 0;
    req_cnt   = 0;
    RegWriteEN_In = rw;
    MemWriteEN_In = we;
    Mem2RegSEL_In = sel;
    ALUResult_In  = alu;
    WriteData_In  = wd;
    PCPlus4_In    = pc4;
    RegWBAddr_In  = rd;
    MemAck        = ack_idle;
    MemRData      = 32'hBADB_AD00;
    if (rw && give_ack) begin
      e.rd = rd;
      e.data = exp_wb;
      wb_q.push_back(e);
    end
    if (exp_req > 0) begin
      r.addr = alu;
      r.wdata = wd;
      r.we = we;
      req_q.push_back(r);
    end
    @(negedge CLOCK);
    stall_cnt += int'(Stall);
    req_cnt   += int'(MemReq);
    @(posedge CLOCK); #1;
    for (int k = 0; k < exp_req; k++) begin
      MemAck   = give_ack && (k == exp_req - 1);
      MemRData = MemAck ? rdata : 32'hBADB_AD00;
      @(negedge CLOCK);
      stall_cnt += int'(Stall);
      req_cnt   += int'(MemReq);
      @(posedge CLOCK); #1;
    end
    MemAck = 1'b0;
    set_nop();
    check($sformatf("%s_stall_cycles", nm), 64'(stall_cnt), 64'(exp_stall));
    check($sformatf("%s_req_cycles", nm), 64'(req_cnt), 64'(exp_req));
  endtask

  initial begin
    RESET    = 1'b1;
    MemAck   = 1'b0;
    MemRData = 32'h0;
    set_nop();
    repeat (2) @(posedge CLOCK);
    #1;
    check("rst_memreq", 64'(MemReq), 64'd0);
    check("rst_memwe", 64'(MemWE), 64'd0);
    check("rst_memaddr", 64'(MemAddr), 64'd0);
    check("rst_memwdata", 64'(MemWData), 64'd0);
    check("rst_regwe", 64'(RegWriteEN_Out), 64'd0);
    check("rst_rd", 64'(RegWBAddr_Out), 64'd0);
    check("rst_wbdata", 64'(WBData_Out), 64'd0);
    check("rst_memerror", 64'(MemError), 64'd0);
    check("rst_stall", 64'(Stall), 64'd0);
    RESET = 1'b0;
    idle(1);

    //        name       we    rw    sel    alu           wd            pc4           rd     req  rdata         ack   ackI  exp_wb        stall
    do_instr("alu",      1'b0, 1'b1, 2'b00, 32'h0000_0010, 32'h0,       32'h0,        5'd3,  0, 32'h0,         1'b1, 1'b0, 32'h0000_0010, 0);
    do_instr("load",     1'b0, 1'b1, 2'b01, 32'h0000_0100, 32'h1234,    32'h0,        5'd5,  4, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 4);
    do_instr("store",    1'b1, 1'b0, 2'b00, 32'h0000_0200, 32'h55,      32'h0,        5'd0,  1, 32'h0,         1'b1, 1'b0, 32'h0,         1);
    do_instr("jal",      1'b0, 1'b1, 2'b10, 32'h0000_0999, 32'h0,       32'h0000_0044, 5'd1, 0, 32'h0,         1'b1, 1'b0, 32'h0000_0044, 0);
    do_instr("sel11",    1'b0, 1'b1, 2'b11, 32'h0000_0077, 32'h0,       32'h0000_0088, 5'd2, 0, 32'h0,         1'b1, 1'b0, 32'h0000_0077, 0);
    do_instr("st_prio",  1'b1, 1'b1, 2'b01, 32'h0000_0300, 32'hAA,      32'h0,        5'd4,  2, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0000_0300, 2);
    do_instr("ack_idle", 1'b0, 1'b1, 2'b01, 32'h0000_0500, 32'h0,       32'h0,        5'd6,  2, 32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678, 2);
    do_instr("b2b_a",    1'b0, 1'b1, 2'b01, 32'h0000_0600, 32'h0,       32'h0,        5'd9,  1, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'hA5A5_A5A5, 1);
    do_instr("b2b_b",    1'b0, 1'b1, 2'b01, 32'h0000_0604, 32'h0,       32'h0,        5'd10, 3, 32'h5A5A_5A5A, 1'b1, 1'b0, 32'h5A5A_5A5A, 3);
    idle(3);

    // Reset in the middle of a load's WAIT, with an ack on the reset edge and a late ack after it.
    RegWriteEN_In = 1'b1;
    Mem2RegSEL_In = 2'b01;
    ALUResult_In  = 32'h0000_0400;
    WriteData_In  = 32'h0000_0777;
    RegWBAddr_In  = 5'd7;
    begin
      req_t r;
      r.addr = 32'h0000_0400;
      r.wdata = 32'h0000_0777;
      r.we = 1'b0;
      req_q.push_back(r);
    end
    @(posedge CLOCK); #1;
    @(negedge CLOCK);
    check("rstw_memreq_before", 64'(MemReq), 64'd1);
    RESET    = 1'b1;
    MemAck   = 1'b1;
    MemRData = 32'h1111_2222;
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    set_nop();
    check("rstw_memreq", 64'(MemReq), 64'd0);
    check("rstw_regwe", 64'(RegWriteEN_Out), 64'd0);
    check("rstw_memaddr", 64'(MemAddr), 64'd0);
    check("rstw_wbdata", 64'(WBData_Out), 64'd0);
    @(posedge CLOCK); #1;
    MemAck = 1'b0;
    check("late_ack_memreq", 64'(MemReq), 64'd0);
    check("late_ack_regwe", 64'(RegWriteEN_Out), 64'd0);
    check("late_ack_stall", 64'(Stall), 64'd0);
    idle(2);

`ifdef MEM_TIMEOUT_EN
    do_instr("timeout", 1'b0, 1'b1, 2'b01, 32'h0000_0700, 32'h0, 32'h0, 5'd8, 4, 32'h0, 1'b0, 1'b0, 32'h0, 4);
    check("timeout_memerror", 64'(MemError), 64'd1);
    check("timeout_memreq", 64'(MemReq), 64'd0);
    idle(3);
    check("timeout_sticky", 64'(MemError), 64'd1);
    RESET = 1'b1;
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    check("timeout_cleared", 64'(MemError), 64'd0);
`else
    check("memerror_tied", 64'(MemError), 64'd0);
`endif

    idle(3);
    check("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    check("req_queue_drained", 64'(req_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the number of cycles a request may wait for MemAck before abort (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have port CLOCK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports RegWriteEN_In / MemWriteEN_In  input  1 each  register-write and memory-write enables from EX/MEM.
REQ-005 SHALL have port Mem2RegSEL_In  input  2  writeback select: 00 ALU, 01 memory, 10 PC+4, 11 ALU (reserved).
REQ-006 SHALL have ports ALUResult_In / WriteData_In / PCPlus4_In  input  32 each  address or result, store data, and link value.
REQ-007 SHALL have port RegWBAddr_In  input  5  destination register.
REQ-008 SHALL have ports MemReq / MemWE  output  1 each  request valid and write strobe to data memory.
REQ-009 SHALL have ports MemAddr / MemWData  output  32 each  latched address and store data.
REQ-010 SHALL have ports MemAck  input  1  and MemRData  input  32  memory completion and load data.
REQ-011 SHALL have port Stall  output  1  holds the upstream pipeline registers while high.
REQ-012 SHALL have ports RegWriteEN_Out  output  1, RegWBAddr_Out  output  5, WBData_Out  output  32  MEM/WB register.
REQ-013 SHALL have port MemError  output  1  sticky timeout flag.

Function
REQ-014 An access SHALL be a store when MemWriteEN_In=1, or a load when Mem2RegSEL_In=01 and MemWriteEN_In=0; a store SHALL take priority, with WB data = ALUResult_In.
REQ-015 The FSM SHALL have states IDLE and WAIT.
REQ-016 In IDLE with an access present, Stall SHALL be 1 combinationally, and on the next edge the FSM SHALL go to WAIT, latching MemAddr, MemWData and MemWE.
REQ-017 MemReq SHALL be 1 exactly while in WAIT, with MemAddr, MemWData and MemWE held stable.
REQ-018 In WAIT, Stall SHALL equal NOT MemAck; on the MemAck cycle the FSM SHALL return to IDLE and the MEM/WB register SHALL load.
REQ-019 Minimum access latency SHALL be 2 cycles (IDLE, then WAIT with immediate ack); non-access instructions SHALL pass with 1-cycle latency and Stall=0.
REQ-020 WBData_Out SHALL load MemRData for loads, PCPlus4_In for select 10, and ALUResult_In otherwise.
REQ-021 On every edge where Stall=1, the MEM/WB register SHALL load a bubble: RegWriteEN_Out=0, other fields unchanged.
REQ-022 MemAck SHALL be ignored in IDLE.
REQ-023 Back-to-back accesses SHALL each spend one IDLE cycle before their WAIT; no request SHALL be issued twice for one instruction.

Reset
REQ-024 RESET SHALL force state IDLE, and MemReq, MemWE, MemAddr, MemWData, RegWriteEN_Out, RegWBAddr_Out, WBData_Out and MemError to 0 on the next edge.
REQ-025 RESET asserted during WAIT SHALL abort the access, and a MemAck coinciding with RESET SHALL be discarded.

Configuration
REQ-026 With macro MEM_TIMEOUT_EN defined, a counter SHALL count WAIT cycles.
REQ-027 With MEM_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without ack SHALL cause: Stall=0 that cycle; FSM to IDLE; MemReq low next cycle; a bubble in WB; MemError set until RESET.
REQ-028 Without MEM_TIMEOUT_EN, WAIT SHALL persist until MemAck, and MemError SHALL be tied 0.

Structure
REQ-029 Package mem_pkg SHALL hold the writeback-select encodings WB_SEL_ALU, WB_SEL_MEM and WB_SEL_PC4, and the FSM state type.
REQ-030 Sub-module mem_timeout_counter SHALL be instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-031 ALU op: Mem2RegSEL=00, ALUResult=0x10, RegWBAddr=3 -> next cycle WBData_Out=0x10, RegWriteEN_Out=1, Stall never high.
REQ-032 Load from 0x100, MemAck after 3 WAIT cycles with MemRData=0xDEADBEEF -> Stall high 4 cycles, 3 bubbles, then WBData_Out=0xDEADBEEF.
REQ-033 Store of 0x55 to 0x200 with same-cycle ack -> MemReq=1, MemWE=1 for 1 cycle, MemAddr=0x200, MemWData=0x55, Stall 1 cycle.
REQ-034 RESET during WAIT of a load -> MemReq=0 next cycle, late MemAck ignored, RegWriteEN_Out=0.
REQ-035 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> abort after 4 WAIT cycles, MemError=1, sticky until RESET.
REQ-036 JAL path: Mem2RegSEL=10, PCPlus4=0x44 -> WBData_Out=0x44, no memory request.
